// File: rtl/threshold_monitor.sv
// threshold_monitor: hysteresis stage behind the 4-bit magnitude comparator.
// The alarm rises after SET_CNT consecutive "greater" samples. It falls after
// CLR_CNT consecutive "equal/less" samples. Valid samples whose flags are not
// one-hot are rejected and reported on err.
// Optional build macro THRESH_MON_STATS_EN adds an 8-bit saturating
// alarm_events counter. It counts fresh alarm entries from IDLE or ARMING.
module threshold_monitor #(
    parameter int SET_CNT = 3,
    parameter int CLR_CNT = 2,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             G,
    input  logic             E,
    input  logic             L,
    output logic             alarm,
    output logic             pending,
    output logic [CNT_W-1:0] streak,
    output logic             err
`ifdef THRESH_MON_STATS_EN
    ,
    output logic [7:0]       alarm_events
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMING,
        S_ALARM,
        S_CLEARING
    } state_t;

    localparam logic [CNT_W-1:0] SET_V = CNT_W'(SET_CNT);
    localparam logic [CNT_W-1:0] CLR_V = CNT_W'(CLR_CNT);
    localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] cnt_inc;
    logic             one_hot;
    logic             take;
    logic             reject;
    logic             up;

    // Classify the incoming sample: accepted (one-hot) or rejected.
    always_comb begin
        one_hot = ({G, E, L} == 3'b100) || ({G, E, L} == 3'b010) ||
                  ({G, E, L} == 3'b001);
        take    = in_valid && one_hot;
        reject  = in_valid && !one_hot;
        up      = G;
        cnt_inc = streak + ONE_V;
    end

    // Next-state and next-count logic; rejected or absent samples hold both.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -> no latches.
        state_nx = state;
        cnt_nx   = streak;
        if (take) begin
            unique case (state)
                S_IDLE: begin
                    if (up) begin
                        if (SET_V == ONE_V) begin
                            state_nx = S_ALARM;
                            cnt_nx   = '0;
                        end else begin
                            state_nx = S_ARMING;
                            cnt_nx   = ONE_V;
                        end
                    end else begin
                        cnt_nx = '0;
                    end
                end
                S_ARMING: begin
                    if (up) begin
                        if (cnt_inc == SET_V) begin
                            state_nx = S_ALARM;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end else begin
                        state_nx = S_IDLE;
                        cnt_nx   = '0;
                    end
                end
                S_ALARM: begin
                    if (up) begin
                        cnt_nx = '0;
                    end else if (CLR_V == ONE_V) begin
                        state_nx = S_IDLE;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = S_CLEARING;
                        cnt_nx   = ONE_V;
                    end
                end
                S_CLEARING: begin
                    if (up) begin
                        state_nx = S_ALARM;
                        cnt_nx   = '0;
                    end else if (cnt_inc == CLR_V) begin
                        state_nx = S_IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs all update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            streak  <= '0;
            alarm   <= 1'b0;
            pending <= 1'b0;
            err     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state   <= state_nx;
            streak  <= cnt_nx;
            alarm   <= (state_nx == S_ALARM) || (state_nx == S_CLEARING);
            pending <= (state_nx == S_ARMING) || (state_nx == S_CLEARING);
            err     <= reject;
        end
    end

`ifdef THRESH_MON_STATS_EN
    logic fresh_alarm;

    // A fresh alarm is an entry into ALARM from IDLE or ARMING. Re-entry from CLEARING is excluded.
    always_comb begin
        fresh_alarm = (state_nx == S_ALARM) &&
                      ((state == S_IDLE) || (state == S_ARMING));
    end

    // Saturating count of fresh alarm entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_events <= 8'd0;
        end else if (fresh_alarm && (alarm_events != 8'hFF)) begin
            alarm_events <= alarm_events + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_threshold_monitor.sv
// Self-checking bench for threshold_monitor (SET_CNT=3, CLR_CNT=2).
// A sample-level model tracks the alarm level and the run length of the current streak.
// It is compared against the DUT every falling edge.
// Directed sequences add hand-computed literal checks.
module tb_threshold_monitor;

    localparam int SET_CNT = 3;
    localparam int CLR_CNT = 2;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             G, E, L;
    logic             alarm, pending, err;
    logic [CNT_W-1:0] streak;
`ifdef THRESH_MON_STATS_EN
    logic [7:0]       alarm_events;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model state
    bit m_alarm;
    int m_run;
    bit m_err;
    int m_ev;

    threshold_monitor #(
        .SET_CNT(SET_CNT),
        .CLR_CNT(CLR_CNT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .G       (G),
        .E       (E),
        .L       (L),
        .alarm   (alarm),
        .pending (pending),
        .streak  (streak),
        .err     (err)
`ifdef THRESH_MON_STATS_EN
        ,
        .alarm_events(alarm_events)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the alarm level plus the length of the run that is trying to flip it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_alarm = 1'b0;
            m_run   = 0;
            m_err   = 1'b0;
            m_ev    = 0;
        end else begin
            m_err = 1'b0;
            if (in_valid) begin
                if ($countones({G, E, L}) != 1) begin
                    m_err = 1'b1;
                end else if (!m_alarm) begin
                    if (G) begin
                        m_run++;
                        if (m_run == SET_CNT) begin
                            m_alarm = 1'b1;
                            m_run   = 0;
                            if (m_ev < 255) m_ev++;
                        end
                    end else begin
                        m_run = 0;
                    end
                end else begin
                    if (!G) begin
                        m_run++;
                        if (m_run == CLR_CNT) begin
                            m_alarm = 1'b0;
                            m_run   = 0;
                        end
                    end else begin
                        m_run = 0;
                    end
                end
            end
        end
    end

    // Compare the DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_alarm",   32'(alarm),   32'(m_alarm));
            check("cyc_pending", 32'(pending), 32'(m_run != 0));
            check("cyc_streak",  32'(streak),  32'(m_run));
            check("cyc_err",     32'(err),     32'(m_err));
`ifdef THRESH_MON_STATS_EN
            check("cyc_events",  32'(alarm_events), 32'(m_ev));
`endif
        end
    end

    // Drive one cycle of input, then settle 1 time unit past the consuming edge.
    task automatic step(input logic v, input logic [2:0] gel);
        in_valid  = v;
        {G, E, L} = gel;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic a, input logic p,
                              input int s, input logic e);
        check({name, "_alarm"},   32'(alarm),   32'(a));
        check({name, "_pending"}, 32'(pending), 32'(p));
        check({name, "_streak"},  32'(streak),  32'(s));
        check({name, "_err"},     32'(err),     32'(e));
    endtask

    localparam logic [2:0] UP = 3'b100, EQ = 3'b010, LT = 3'b001;

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        {G, E, L} = 3'b000;
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;

        // Reset, then idle
        repeat (2) @(posedge clk);
        #1;
        expect_out("in_reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, UP);
            expect_out("idle", 0, 0, 0, 0);
        end

        // Arming to alarm
        step(1'b1, UP); expect_out("arm1", 0, 1, 1, 0);
        step(1'b1, UP); expect_out("arm2", 0, 1, 2, 0);
        step(1'b1, UP); expect_out("arm3", 1, 0, 0, 0);
        step(1'b1, EQ); expect_out("clr1", 1, 1, 1, 0);
        step(1'b1, LT); expect_out("clr2", 0, 0, 0, 0);

        // G,G,E aborts the arming
        step(1'b1, UP); step(1'b1, UP);
        step(1'b1, EQ); expect_out("abort", 0, 0, 0, 0);

        // Clearing: from ALARM apply L,G,L,E
        step(1'b1, UP); step(1'b1, UP); step(1'b1, UP);
        step(1'b1, LT); expect_out("c_l1", 1, 1, 1, 0);
        step(1'b1, UP); expect_out("c_g",  1, 0, 0, 0);
        step(1'b1, LT); expect_out("c_l2", 1, 1, 1, 0);
        step(1'b1, EQ); expect_out("c_e",  0, 0, 0, 0);

        // An illegal flag pattern in ARMING is rejected without breaking the streak
        step(1'b1, UP); step(1'b1, UP);
        step(1'b1, 3'b110); expect_out("bad110", 0, 1, 2, 1);
        step(1'b1, UP);     expect_out("after_bad", 1, 0, 0, 0);
        step(1'b1, EQ); step(1'b1, EQ);
        expect_out("back_idle", 0, 0, 0, 0);

        // Other illegal patterns in IDLE; invalid cycles never raise err
        step(1'b1, 3'b000); expect_out("bad000", 0, 0, 0, 1);
        step(1'b1, 3'b111); expect_out("bad111", 0, 0, 0, 1);
        step(1'b0, 3'b111); expect_out("nv111",  0, 0, 0, 0);
        step(1'b1, 3'b011); expect_out("bad011", 0, 0, 0, 1);
        step(1'b1, 3'b101); expect_out("bad101", 0, 0, 0, 1);

        // Gaps do not break the streak
        step(1'b1, UP);
        step(1'b0, EQ); step(1'b0, LT); step(1'b0, 3'b000);
        expect_out("gap_hold", 0, 1, 1, 0);
        step(1'b1, UP);
        step(1'b1, UP); expect_out("gap_alarm", 1, 0, 0, 0);

        // Async reset while CLEARING
        step(1'b1, LT); expect_out("pre_rst", 1, 1, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        expect_out("async_rst", 0, 0, 0, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        step(1'b1, UP); expect_out("post_rst", 0, 1, 1, 0);
        step(1'b1, EQ); expect_out("post_rst2", 0, 0, 0, 0);

`ifdef THRESH_MON_STATS_EN
        // Stats: three full alarm cycles plus one CLEARING->ALARM re-entry
        rst_n = 1'b0; #1;
        check("ev_reset", 32'(alarm_events), 32'd0);
        @(posedge clk); #2; rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, UP); step(1'b1, UP); step(1'b1, UP);
            if (k == 0) begin
                step(1'b1, LT); step(1'b1, UP);
            end
            step(1'b1, EQ); step(1'b1, EQ);
        end
        check("ev_three", 32'(alarm_events), 32'd3);
        for (int k = 0; k < 300; k++) begin
            step(1'b1, UP); step(1'b1, UP); step(1'b1, UP);
            step(1'b1, LT); step(1'b1, LT);
        end
        check("ev_sat", 32'(alarm_events), 32'd255);
`endif

        step(1'b0, 3'b000);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
